// File: rtl/ctrl_decode_stage.sv
// Registered RV32IM decode/control stage with valid/ready flow control, flush and
// an M-extension latency stall. Optional `CTRL_ILLEGAL_TRAP_EN adds the illegal output.
module ctrl_decode_stage #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        pc_src,
    output logic        imm_sel,
    output logic        jump_sel,
    output logic        jal,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  mem_type,
    output logic        md_op,
    output logic        md_busy,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        MD_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       pc_src;
        logic       imm_sel;
        logic       jump_sel;
        logic       jal;
        logic [1:0] mem_to_reg;
        logic [2:0] mem_type;
        logic       md_op;
`ifdef CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } bundle_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t           state_q, state_d;
    bundle_t          bundle_q, bundle_d;
    bundle_t          dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7            = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    function automatic logic [2:0] width_type(input logic [2:0] f3, input logic is_load);
        logic [2:0] t;
        t = 3'b000;
        case (f3)
            3'd0: t = 3'b000;
            3'd1: t = 3'b010;
            3'd2: t = 3'b011;
            3'd4: t = is_load ? 3'b100 : 3'b000;
            3'd5: t = is_load ? 3'b110 : 3'b000;
            default: t = 3'b000;
        endcase
        return t;
    endfunction

    // Instruction decode into the control bundle.
    always_comb begin
        dec = '0;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.md_op     = (funct7 == F7_MD);
`ifdef CTRL_ILLEGAL_TRAP_EN
                dec.illegal   = !((funct7 == F7_BASE) || (funct7 == F7_ALT) || (funct7 == F7_MD));
`endif
            end
            OP_IALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 2'b01;
                dec.mem_type   = width_type(funct3, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
                dec.illegal    = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
`endif
            end
            OP_STORE: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.mem_type  = width_type(funct3, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
                dec.illegal   = (funct3 >= 3'd3);
`endif
            end
            OP_BRANCH: begin
                dec.alu_src = 1'b1;
                dec.branch  = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.pc_src     = 1'b1;
                dec.imm_sel    = 1'b1;
                dec.jump_sel   = 1'b1;
                dec.mem_to_reg = 2'b10;
                dec.jal        = (opcode == OP_JAL);
                dec.branch     = (opcode == OP_JALR);
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.pc_src    = 1'b1;
                dec.imm_sel   = 1'b1;
                dec.jump_sel  = 1'b1;
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                dec.illegal = 1'b1;
`endif
            end
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
`endif
    end

    // Handshake: a transfer happens on a clock edge where valid and ready are both high.
    // Upstream: accept = in_valid & in_ready, ready never asserted during flush.
    // Downstream: the bundle is held unchanged while out_valid & !out_ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        md_busy   = 1'b0;
        case (state_q)
            IDLE:    in_ready = !flush;
            HOLD: begin
                in_ready  = !flush && out_ready;
                out_valid = 1'b1;
            end
            MD_WAIT: md_busy = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) state_d = dec.md_op ? MD_WAIT : HOLD;
                end
                HOLD: begin
                    if (accept)         state_d = dec.md_op ? MD_WAIT : HOLD;
                    else if (out_ready) state_d = IDLE;
                end
                MD_WAIT: begin
                    if (cnt_q == '0) state_d = HOLD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Bundle and latency counter load on accept; counter runs down only in MD_WAIT.
    always_comb begin
        bundle_d = bundle_q;
        cnt_d    = cnt_q;
        if (flush) begin
            bundle_d = '0;
            cnt_d    = '0;
        end else if (accept) begin
            bundle_d = dec;
            if (dec.md_op) cnt_d = funct3[2] ? DIV_CNT : MUL_CNT;
            else           cnt_d = '0;
        end else if ((state_q == MD_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bundle_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
            cnt_q    <= cnt_d;
        end
    end

    assign reg_write   = bundle_q.reg_write;
    assign alu_src     = bundle_q.alu_src;
    assign mem_read    = bundle_q.mem_read;
    assign mem_write   = bundle_q.mem_write;
    assign branch      = bundle_q.branch;
    assign pc_src      = bundle_q.pc_src;
    assign imm_sel     = bundle_q.imm_sel;
    assign jump_sel    = bundle_q.jump_sel;
    assign jal         = bundle_q.jal;
    assign mem_to_reg  = bundle_q.mem_to_reg;
    assign mem_type    = bundle_q.mem_type;
    assign md_op       = bundle_q.md_op;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal     = bundle_q.illegal;
`endif
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: directed timing checks plus a random
// handshake stream compared against an independent decode model.
module tb_ctrl_decode_stage;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam int W = 16;
`else
    localparam int W = 15;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr;
    logic        reg_write, alu_src, mem_read, mem_write, branch, pc_src, imm_sel, jump_sel, jal;
    logic [1:0]  mem_to_reg;
    logic [2:0]  mem_type;
    logic        md_op, md_busy;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic [1:0]  dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    ctrl_decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .pc_src     (pc_src),
        .imm_sel    (imm_sel),
        .jump_sel   (jump_sel),
        .jal        (jal),
        .mem_to_reg (mem_to_reg),
        .mem_type   (mem_type),
        .md_op      (md_op),
        .md_busy    (md_busy),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] obs();
`ifdef CTRL_ILLEGAL_TRAP_EN
        return {reg_write, alu_src, mem_read, mem_write, branch, pc_src, imm_sel, jump_sel, jal,
                mem_to_reg, mem_type, md_op, illegal};
`else
        return {reg_write, alu_src, mem_read, mem_write, branch, pc_src, imm_sel, jump_sel, jal,
                mem_to_reg, mem_type, md_op};
`endif
    endfunction

    // reference decode model
    function automatic logic [W-1:0] model(input logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic rw = 0, as = 0, mr = 0, mw = 0, br = 0, ps = 0, is = 0, js = 0, jl = 0, md = 0, ill = 0;
        logic [1:0] m2r = 2'b00;
        logic [2:0] mt = 3'b000;
        case (op)
            OP_R: begin
                rw = 1; md = (f7 == 7'b0000001);
                ill = !(f7 == 7'b0000000 || f7 == 7'b0100000 || f7 == 7'b0000001);
            end
            OP_IALU: begin rw = 1; as = 1; end
            OP_LOAD: begin
                rw = 1; as = 1; mr = 1; m2r = 2'b01;
                mt = (f3 == 1) ? 3'b010 : (f3 == 2) ? 3'b011 : (f3 == 4) ? 3'b100 :
                     (f3 == 5) ? 3'b110 : 3'b000;
                ill = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            OP_STORE: begin
                as = 1; mw = 1;
                mt = (f3 == 1) ? 3'b010 : (f3 == 2) ? 3'b011 : 3'b000;
                ill = (f3 >= 3);
            end
            OP_BRANCH: begin as = 1; br = 1; end
            OP_JAL:    begin rw = 1; as = 1; ps = 1; is = 1; js = 1; jl = 1; m2r = 2'b10; end
            OP_JALR:   begin rw = 1; as = 1; ps = 1; is = 1; js = 1; br = 1; m2r = 2'b10; end
            OP_LUI:    begin rw = 1; as = 1; end
            OP_AUIPC:  begin rw = 1; as = 1; ps = 1; is = 1; js = 1; end
            default:   ill = 1;
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (ill) return {{(W-1){1'b0}}, 1'b1};
        return {rw, as, mr, mw, br, ps, is, js, jl, m2r, mt, md, 1'b0};
`else
        return {rw, as, mr, mw, br, ps, is, js, jl, m2r, mt, md};
`endif
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        logic [14:0] r;
        r = 15'($urandom);
        return {f7, r[14:5], f3, r[4:0], op};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [2:0] f3;
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 11))
            0:  return mk(($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000, f3, OP_R);
            1:  return mk(7'b0000001, f3, OP_R);
            2:  return mk(7'($urandom), f3, OP_IALU);
            3:  return mk(7'($urandom), f3, OP_LOAD);
            4:  return mk(7'($urandom), f3, OP_STORE);
            5:  return mk(7'($urandom), f3, OP_BRANCH);
            6:  return mk(7'($urandom), f3, OP_JAL);
            7:  return mk(7'($urandom), f3, OP_JALR);
            8:  return mk(7'($urandom), f3, OP_LUI);
            9:  return mk(7'($urandom), f3, OP_AUIPC);
            10: return mk(7'($urandom), f3, 7'b0001111);
            default: return mk(7'b1111111, f3, OP_R);
        endcase
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_extra_output", 1, 0);
            else check("sb_bundle", obs(), exp_q.pop_front());
        end
    end

    task automatic run_md(input logic [2:0] f3, input int lat, input string tag);
        logic [31:0] nxt;
        instr = mk(7'b0000001, f3, OP_R);
        in_valid = 1;
        exp_q.push_back(model(instr));
        step();
        nxt = mk(7'b0000000, 3'd0, OP_R);
        instr = nxt;
        exp_q.push_back(model(nxt));
        for (int k = 1; k <= lat + 1; k++) begin
            mid();
            check({tag, "_busy"}, md_busy, (k <= lat));
            check({tag, "_out_valid"}, out_valid, (k == lat + 1));
            check({tag, "_in_ready"}, in_ready, (k == lat + 1));
            if (k == lat + 1) check({tag, "_md_op"}, md_op, 1);
            step();
        end
        in_valid = 0;
        mid();
        check({tag, "_next_valid"}, out_valid, 1);
        check({tag, "_next_md_op"}, md_op, 0);
        step();
        mid();
        check({tag, "_idle"}, out_valid, 0);
        step();
    endtask

    initial begin
        logic [31:0] i_jal, i_auipc, i_add;
        logic        saw_ov;
        int          sent, cyc;

        rst = 1; in_valid = 0; flush = 0; out_ready = 1; instr = '0;
        step();
        step();
        mid();
        check("rst_out_valid", out_valid, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_bundle", obs(), 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_state", dbg_state, 0);
        step();
        rst = 0;

        // ADD, LW, SW back to back
        in_valid = 1;
        instr = mk(7'b0000000, 3'd0, OP_R); exp_q.push_back(model(instr));
        mid();
        check("b2b_c0_in_ready", in_ready, 1);
        check("b2b_c0_out_valid", out_valid, 0);
        step();
        instr = mk(7'($urandom), 3'd2, OP_LOAD); exp_q.push_back(model(instr));
        mid();
        check("b2b_c1_out_valid", out_valid, 1);
        check("b2b_c1_in_ready", in_ready, 1);
        step();
        instr = mk(7'($urandom), 3'd2, OP_STORE); exp_q.push_back(model(instr));
        mid();
        check("b2b_c2_out_valid", out_valid, 1);
        check("lw_mem_read", mem_read, 1);
        check("lw_mem_to_reg", mem_to_reg, 2'b01);
        check("lw_mem_type", mem_type, 3'b011);
        step();
        in_valid = 0;
        mid();
        check("b2b_c3_out_valid", out_valid, 1);
        check("sw_mem_write", mem_write, 1);
        check("sw_reg_write", reg_write, 0);
        step();
        mid();
        check("b2b_c4_out_valid", out_valid, 0);
        step();

        // M-ops: MUL, MULHU, DIV, REMU
        run_md(3'd0, 2, "mul");
        run_md(3'd3, 2, "mulhu");
        run_md(3'd4, 33, "div");
        run_md(3'd7, 33, "remu");

        // JAL held under backpressure, then AUIPC
        out_ready = 0;
        in_valid = 1;
        i_jal = mk(7'($urandom), 3'($urandom), OP_JAL);
        i_auipc = mk(7'($urandom), 3'($urandom), OP_AUIPC);
        instr = i_jal; exp_q.push_back(model(i_jal));
        mid();
        check("jal_accept_ready", in_ready, 1);
        step();
        instr = i_auipc; exp_q.push_back(model(i_auipc));
        for (int c = 1; c <= 3; c++) begin
            mid();
            check("jal_hold_valid", out_valid, 1);
            check("jal_hold_in_ready", in_ready, 0);
            check("jal_hold_bundle", obs(), model(i_jal));
            check("jal_hold_jal", jal, 1);
            check("jal_hold_m2r", mem_to_reg, 2'b10);
            check("jal_hold_mem_read", mem_read, 0);
            step();
        end
        out_ready = 1;
        mid();
        check("jal_release_in_ready", in_ready, 1);
        check("jal_release_bundle", obs(), model(i_jal));
        step();
        in_valid = 0;
        mid();
        check("auipc_valid", out_valid, 1);
        check("auipc_reg_write", reg_write, 1);
        step();
        mid();
        check("auipc_idle", out_valid, 0);
        step();

        // flush at cycle 10 of a DIV
        instr = mk(7'b0000001, 3'd5, OP_R);
        in_valid = 1;
        step();
        in_valid = 0;
        for (int c = 1; c < 10; c++) step();
        flush = 1;
        in_valid = 1;
        instr = mk(7'b0000000, 3'd0, OP_R);
        mid();
        check("flush_in_ready", in_ready, 0);
        check("flush_busy_before", md_busy, 1);
        step();
        flush = 0;
        in_valid = 0;
        mid();
        check("flush_out_valid", out_valid, 0);
        check("flush_md_busy", md_busy, 0);
        check("flush_state", dbg_state, 0);
        check("flush_in_ready_after", in_ready, 1);
        saw_ov = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            mid();
            if (out_valid) saw_ov = 1;
        end
        check("flush_no_div_output", saw_ov, 0);
        step();
        i_add = mk(7'b0100000, 3'd0, OP_R);
        instr = i_add; in_valid = 1; exp_q.push_back(model(i_add));
        step();
        in_valid = 0;
        mid();
        check("post_flush_add_valid", out_valid, 1);
        check("post_flush_add_rw", reg_write, 1);
        step();

        // unknown opcode
        instr = mk(7'($urandom), 3'($urandom), 7'b1111111);
        in_valid = 1; exp_q.push_back(model(instr));
        step();
        in_valid = 0;
        mid();
        check("unk_valid", out_valid, 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("unk_illegal", illegal, 1);
        check("unk_bundle_zero", obs() >> 1, 0);
`else
        check("unk_bundle_zero", obs(), 0);
`endif
        step();

        // random stream with random backpressure
        sent = 0;
        cyc = 0;
        while ((sent < 40 || exp_q.size() != 0) && cyc < 4000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 40 && $urandom_range(0, 2) != 0) begin
                in_valid = 1;
                instr = rand_instr();
            end else begin
                in_valid = 0;
            end
            mid();
            if (in_valid && in_ready) begin
                exp_q.push_back(model(instr));
                sent++;
            end
            step();
            cyc++;
        end
        check("rand_drain_in_budget", (cyc < 4000), 1);
        in_valid = 0;
        out_ready = 1;
        step();
        step();

        // reset while a DIV is counting
        instr = mk(7'b0000001, 3'd4, OP_R);
        in_valid = 1;
        step();
        in_valid = 0;
        for (int c = 1; c < 5; c++) step();
        mid();
        check("rstmd_busy_before", md_busy, 1);
        step();
        rst = 1;
        #1;
        check("rstmd_out_valid", out_valid, 0);
        check("rstmd_md_busy", md_busy, 0);
        check("rstmd_in_ready", in_ready, 1);
        check("rstmd_state", dbg_state, 0);
        step();
        rst = 0;
        step();
        mid();
        check("rstmd_after_valid", out_valid, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
